// File: rtl/sobel_loader_ctrl_pkg.sv
// Shared types and defaults for the Sobel loader controller slice.
package sobel_pkg;

  localparam int DATA_W    = 8;
  localparam int IMG_W_DEF = 256;
  localparam int IMG_H_DEF = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    LAST = 2'd2
  } state_t;

endpackage

// File: rtl/sobel_loader_ctrl_if.sv
// Raw pixel stream (valid/ready) into the Sobel loader controller.
interface sobel_loader_ctrl_if #(
  parameter int DATA_W = sobel_pkg::DATA_W
);

  logic              PixValid;
  logic [DATA_W-1:0] PixData;
  logic              PixReady;

  modport master (output PixValid, output PixData, input  PixReady);
  modport slave  (input  PixValid, input  PixData, output PixReady);

endinterface

// File: rtl/sobel_loader_ctrl_pixel_coord_counter.sv
// Column/row position of the next pixel to be pushed into the line shift register.
module pixel_coord_counter
  import sobel_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int COL_W = $clog2(IMG_W),
  parameter int ROW_W = $clog2(IMG_H)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             clear,
  input  logic             inc,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             last_pix
);

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (inc) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= (row == ROW_MAX) ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  always_comb begin
    last_pix = (col == COL_MAX) && (row == ROW_MAX);
  end

endmodule

// File: rtl/sobel_loader_ctrl.sv
// Feeds the 3-row line shift register from a pixel stream and tags each push
// with its coordinates, window-valid and end-of-frame.
module sobel_loader_ctrl
  import sobel_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int DATA_W = sobel_pkg::DATA_W,
  parameter int COL_W  = $clog2(IMG_W),
  parameter int ROW_W  = $clog2(IMG_H)
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                Start,
  input  logic                Abort,
  sobel_loader_ctrl_if.slave  pix,
  output logic                SR_Enable,
  output logic [DATA_W-1:0]   SR_DataIn,
  output logic                WinValid,
  output logic [COL_W-1:0]    Col,
  output logic [ROW_W-1:0]    Row,
  output logic                FrameDone,
  output logic                Busy
);

  state_t           state, stateNext;
  logic             accept;
  logic             clrCnt;
  logic [COL_W-1:0] cntCol;
  logic [ROW_W-1:0] cntRow;
  logic             lastPix;

  pixel_coord_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_coord (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .clear    (clrCnt),
    .inc      (accept),
    .col      (cntCol),
    .row      (cntRow),
    .last_pix (lastPix)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (Abort) begin
      stateNext = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (Start) stateNext = LOAD;
        LOAD:    if (pix.PixValid && lastPix) stateNext = LAST;
        LAST:    stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  // Abort blocks acceptance so a half-pushed pixel never reaches the shift register.
  always_comb begin
    pix.PixReady = (state == LOAD);
    Busy         = (state != IDLE);
    accept       = (state == LOAD) && pix.PixValid && !Abort;
    clrCnt       = Abort || ((state == IDLE) && Start);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      SR_Enable <= 1'b0;
      SR_DataIn <= '0;
      WinValid  <= 1'b0;
      Col       <= '0;
      Row       <= '0;
      FrameDone <= 1'b0;
    end else begin
      SR_Enable <= accept;
      WinValid  <= accept && (cntRow >= ROW_W'(2)) && (cntCol >= COL_W'(2));
      FrameDone <= accept && lastPix;
      if (accept) begin
        SR_DataIn <= pix.PixData;
        Col       <= cntCol;
        Row       <= cntRow;
      end
    end
  end

endmodule

// File: tb/tb_sobel_loader_ctrl.sv
// Directed bench for sobel_loader_ctrl on a 4x3 frame.
module tb_sobel_loader_ctrl;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int NPIX = W * H;
  localparam int NLOG = 32;

  logic       CLK;
  logic       RST_N;
  logic       Start;
  logic       Abort;
  logic       SR_Enable;
  logic [7:0] SR_DataIn;
  logic       WinValid;
  logic [1:0] Col;
  logic [1:0] Row;
  logic       FrameDone;
  logic       Busy;

  int vecs = 0;
  int errs = 0;

  int logEn[NLOG], logData[NLOG], logCol[NLOG], logRow[NLOG];
  int logWin[NLOG], logDone[NLOG], logBusy[NLOG], logReady[NLOG];

  sobel_loader_ctrl_if #(.DATA_W(8)) bus ();

  sobel_loader_ctrl #(.IMG_W(W), .IMG_H(H), .DATA_W(8)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .Start     (Start),
    .Abort     (Abort),
    .pix       (bus.slave),
    .SR_Enable (SR_Enable),
    .SR_DataIn (SR_DataIn),
    .WinValid  (WinValid),
    .Col       (Col),
    .Row       (Row),
    .FrameDone (FrameDone),
    .Busy      (Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drives one frame (Start pulse, then pixels 0..11) and records nCycles of outputs.
  task automatic run_frame(input int stallAfter, input int stallLen, input int abortAt,
                           input int startAt, input int nCycles);
    int pixIdx = 0;
    int stallCnt = 0;
    bit aborted = 0;
    Start = 1'b1; Abort = 1'b0; bus.PixValid = 1'b0;
    tick();
    for (int c = 0; c < nCycles; c++) begin
      Start = 1'b0; Abort = 1'b0; bus.PixValid = 1'b0;
      if (pixIdx < NPIX && !aborted) begin
        if (stallAfter >= 0 && pixIdx == stallAfter + 1 && stallCnt < stallLen) begin
          stallCnt++;
        end else begin
          bus.PixValid = 1'b1;
          bus.PixData  = 8'(pixIdx);
          if (pixIdx == startAt) Start = 1'b1;
          if (pixIdx == abortAt) begin
            Abort = 1'b1;
            aborted = 1;
          end else if (bus.PixReady) begin
            pixIdx++;
          end
        end
      end
      tick();
      logEn[c]    = int'(SR_Enable);
      logData[c]  = int'(SR_DataIn);
      logCol[c]   = int'(Col);
      logRow[c]   = int'(Row);
      logWin[c]   = int'(WinValid);
      logDone[c]  = int'(FrameDone);
      logBusy[c]  = int'(Busy);
      logReady[c] = int'(bus.PixReady);
    end
    Start = 1'b0; Abort = 1'b0; bus.PixValid = 1'b0;
  endtask

  task automatic test_reset();
    logic [16:0] obs;
    RST_N = 1'b0; Start = 1'b0; Abort = 1'b0;
    bus.PixValid = 1'b0; bus.PixData = 8'h00;
    repeat (2) tick();
    obs = {SR_Enable, SR_DataIn, WinValid, Col, Row, FrameDone, Busy, bus.PixReady};
    vecs++;
    if (obs !== '0) begin
      errs++; $display("FAIL reset_outputs: got %h, expected 0", obs);
    end
    RST_N = 1'b1;
    tick();
    vecs++;
    if (Busy !== 1'b0 || bus.PixReady !== 1'b0) begin
      errs++; $display("FAIL reset_idle: got busy=%b ready=%b, expected 0 0", Busy, bus.PixReady);
    end
  endtask

  task automatic test_basic_frame();
    run_frame(-1, 0, -1, -1, 14);
    for (int k = 0; k < 14; k++) begin
      int expEn = (k < NPIX) ? 1 : 0;
      vecs++;
      if (logEn[k] !== expEn) begin
        errs++; $display("FAIL basic_en k=%0d: got %0d, expected %0d", k, logEn[k], expEn);
      end
      vecs++;
      if (logBusy[k] !== ((k < NPIX) ? 1 : 0)) begin
        errs++; $display("FAIL basic_busy k=%0d: got %0d, expected %0d", k, logBusy[k], (k < NPIX) ? 1 : 0);
      end
      vecs++;
      if (logReady[k] !== ((k < NPIX - 1) ? 1 : 0)) begin
        errs++; $display("FAIL basic_ready k=%0d: got %0d, expected %0d", k, logReady[k], (k < NPIX - 1) ? 1 : 0);
      end
      vecs++;
      if (logDone[k] !== ((k == NPIX - 1) ? 1 : 0)) begin
        errs++; $display("FAIL basic_done k=%0d: got %0d, expected %0d", k, logDone[k], (k == NPIX - 1) ? 1 : 0);
      end
      vecs++;
      if (logWin[k] !== ((k == 10 || k == 11) ? 1 : 0)) begin
        errs++; $display("FAIL basic_win k=%0d: got %0d, expected %0d", k, logWin[k], (k == 10 || k == 11) ? 1 : 0);
      end
      if (k < NPIX) begin
        vecs++;
        if (logData[k] !== k || logCol[k] !== k % W || logRow[k] !== k / W) begin
          errs++;
          $display("FAIL basic_push k=%0d: got data=%0d col=%0d row=%0d, expected %0d %0d %0d",
                   k, logData[k], logCol[k], logRow[k], k, k % W, k / W);
        end
      end
    end
  endtask

  task automatic test_stall();
    run_frame(5, 3, -1, -1, 17);
    for (int k = 0; k < 17; k++) begin
      int p = (k <= 5) ? k : (k <= 8) ? -1 : k - 3;
      vecs++;
      if (logEn[k] !== ((p >= 0 && p < NPIX) ? 1 : 0)) begin
        errs++; $display("FAIL stall_en k=%0d: got %0d, expected %0d", k, logEn[k], (p >= 0 && p < NPIX) ? 1 : 0);
      end
      if (p < 0) begin
        vecs++;
        if (logCol[k] !== 1 || logRow[k] !== 1 || logData[k] !== 5 || logReady[k] !== 1) begin
          errs++;
          $display("FAIL stall_hold k=%0d: got col=%0d row=%0d data=%0d ready=%0d, expected 1 1 5 1",
                   k, logCol[k], logRow[k], logData[k], logReady[k]);
        end
      end else if (p < NPIX) begin
        vecs++;
        if (logData[k] !== p || logCol[k] !== p % W || logRow[k] !== p / W ||
            logWin[k] !== ((p >= 10) ? 1 : 0) || logDone[k] !== ((p == 11) ? 1 : 0)) begin
          errs++;
          $display("FAIL stall_push k=%0d: got data=%0d col=%0d row=%0d win=%0d done=%0d, expected pixel %0d",
                   k, logData[k], logCol[k], logRow[k], logWin[k], logDone[k], p);
        end
      end
    end
    vecs++;
    if (logBusy[15] !== 0 || logBusy[14] !== 1) begin
      errs++; $display("FAIL stall_busy: got %0d%0d, expected 10", logBusy[14], logBusy[15]);
    end
  endtask

  task automatic test_abort();
    int doneSeen = 0;
    run_frame(-1, 0, 7, -1, 12);
    for (int k = 0; k < 12; k++) doneSeen += logDone[k];
    vecs++;
    if (doneSeen !== 0) begin
      errs++; $display("FAIL abort_nodone: got %0d pulses, expected 0", doneSeen);
    end
    vecs++;
    if (logEn[6] !== 1 || logData[6] !== 6) begin
      errs++; $display("FAIL abort_pre: got en=%0d data=%0d, expected 1 6", logEn[6], logData[6]);
    end
    vecs++;
    if (logEn[7] !== 0 || logReady[7] !== 0 || logBusy[7] !== 0 || logWin[7] !== 0) begin
      errs++;
      $display("FAIL abort_idle: got en=%0d ready=%0d busy=%0d win=%0d, expected 0 0 0 0",
               logEn[7], logReady[7], logBusy[7], logWin[7]);
    end
    vecs++;
    if (logCol[7] !== 2 || logRow[7] !== 1) begin
      errs++; $display("FAIL abort_hold: got col=%0d row=%0d, expected 2 1", logCol[7], logRow[7]);
    end
    run_frame(-1, 0, -1, -1, 14);
    vecs++;
    if (logEn[0] !== 1 || logCol[0] !== 0 || logRow[0] !== 0 || logData[0] !== 0) begin
      errs++;
      $display("FAIL abort_restart: got en=%0d col=%0d row=%0d data=%0d, expected 1 0 0 0",
               logEn[0], logCol[0], logRow[0], logData[0]);
    end
    vecs++;
    if (logDone[11] !== 1 || logCol[11] !== 3 || logRow[11] !== 2) begin
      errs++; $display("FAIL abort_refill: got done=%0d col=%0d row=%0d, expected 1 3 2", logDone[11], logCol[11], logRow[11]);
    end
  endtask

  task automatic test_async_reset();
    logic [16:0] obs;
    Start = 1'b1; tick(); Start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.PixValid = 1'b1; bus.PixData = 8'(i);
      tick();
    end
    vecs++;
    if (SR_DataIn !== 8'd5 || Col !== 2'd1 || Row !== 2'd1 || Busy !== 1'b1) begin
      errs++; $display("FAIL areset_pre: got data=%0d col=%0d row=%0d busy=%0d, expected 5 1 1 1", SR_DataIn, Col, Row, Busy);
    end
    #3 RST_N = 1'b0;
    #1;
    obs = {SR_Enable, SR_DataIn, WinValid, Col, Row, FrameDone, Busy, bus.PixReady};
    vecs++;
    if (obs !== '0) begin
      errs++; $display("FAIL areset_now: got %h, expected 0", obs);
    end
    #2 RST_N = 1'b1;
    bus.PixValid = 1'b0;
    tick();
    vecs++;
    if (Busy !== 1'b0 || bus.PixReady !== 1'b0 || SR_Enable !== 1'b0) begin
      errs++; $display("FAIL areset_idle: got busy=%b ready=%b en=%b, expected 0 0 0", Busy, bus.PixReady, SR_Enable);
    end
  endtask

  task automatic test_start_while_busy();
    int pushes = 0;
    run_frame(-1, 0, -1, 4, 14);
    for (int k = 0; k < 14; k++) pushes += logEn[k];
    vecs++;
    if (pushes !== NPIX) begin
      errs++; $display("FAIL busystart_pushes: got %0d, expected %0d", pushes, NPIX);
    end
    vecs++;
    if (logCol[5] !== 1 || logRow[5] !== 1 || logData[5] !== 5) begin
      errs++; $display("FAIL busystart_coord: got col=%0d row=%0d data=%0d, expected 1 1 5", logCol[5], logRow[5], logData[5]);
    end
    vecs++;
    if (logDone[11] !== 1 || logBusy[12] !== 0) begin
      errs++; $display("FAIL busystart_end: got done=%0d busy=%0d, expected 1 0", logDone[11], logBusy[12]);
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 2; f++) begin
      run_frame(-1, 0, -1, -1, 13);
      for (int k = 0; k < 13; k++) begin
        vecs++;
        if (logEn[k] !== ((k < NPIX) ? 1 : 0) || logWin[k] !== ((k == 10 || k == 11) ? 1 : 0) ||
            logDone[k] !== ((k == 11) ? 1 : 0)) begin
          errs++;
          $display("FAIL b2b f=%0d k=%0d: got en=%0d win=%0d done=%0d", f, k, logEn[k], logWin[k], logDone[k]);
        end
      end
      vecs++;
      if (logData[0] !== 0 || logData[11] !== 11 || logBusy[12] !== 0) begin
        errs++; $display("FAIL b2b_data f=%0d: got %0d %0d busy=%0d, expected 0 11 0", f, logData[0], logData[11], logBusy[12]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    tick();
    test_stall();
    tick();
    test_abort();
    tick();
    test_async_reset();
    tick();
    test_start_while_busy();
    tick();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/sobel_loader_ctrl.md
Name: sobel_loader_ctrl

Overview:
- Sequences the 3-row line shift register in the Sobel loader.
- Accepts a raw 8-bit pixel stream through a valid/ready handshake and drives the shift register's Enable and DataIn.
- Tracks the row and column of every pushed pixel and flags when the shift register taps hold a complete 3x3 neighbourhood.
- Signals frame completion to the downstream Sobel core.

Parameters:
- IMG_W, 256, pixels per image row (>= 3).
- IMG_H, 256, rows per frame (>= 3).
- DATA_W, 8, pixel width; must match the shift register DataIn width.
- COL_W, $clog2(IMG_W), width of the Col output.
- ROW_W, $clog2(IMG_H), width of the Row output.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- Start  in  1  one-cycle pulse that starts a frame. Ignored unless the state is IDLE.
- Abort  in  1  synchronous abort; returns to IDLE on the next edge.
- PixValid  in  1  source has a pixel on PixData.
- PixData  in  DATA_W  source pixel.
- PixReady  out  1  controller can accept a pixel.
- SR_Enable  out  1  shift-register enable (one shift per high cycle).
- SR_DataIn  out  DATA_W  shift-register data in.
- WinValid  out  1  pixel pushed this cycle completes a valid 3x3 window.
- Col  out  COL_W  column of the pixel pushed this cycle.
- Row  out  ROW_W  row of the pixel pushed this cycle.
- FrameDone  out  1  one-cycle pulse on the last pixel of the frame.
- Busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (RST_N low, asynchronous): state=IDLE. All outputs are 0, including SR_DataIn, Col, Row and the internal counters. Reset mid-frame discards the frame with no FrameDone.
- States are IDLE, LOAD and LAST.
- IDLE: PixReady=0. On Start=1, go to LOAD and clear the column and row counters.
- LOAD: PixReady=1. A pixel is accepted when PixValid && PixReady.
  - Acceptance increments the column counter.
  - At IMG_W-1 the column counter wraps to 0 and the row counter increments.
  - Accepting the pixel at (IMG_H-1, IMG_W-1) moves the state to LAST.
- LAST: PixReady=0. The next edge returns to IDLE.
- Latency is 1 cycle. On the edge after an acceptance, the following are registered and valid in the same cycle:
  - SR_Enable=1.
  - SR_DataIn=PixData.
  - Col and Row = coordinates of the accepted pixel.
- With no acceptance, SR_Enable=0 and SR_DataIn, Col and Row hold their last values.
- WinValid=SR_Enable && Row>=2 && Col>=2, registered alongside the other outputs. Exactly (IMG_H-2)*(IMG_W-2) pulses occur per frame.
- FrameDone=1 in the same cycle as the SR_Enable of the final pixel, i.e. the first cycle in LAST. It is 0 otherwise.
- Source stall (PixValid=0 in LOAD): no shift occurs, counters hold, PixReady stays 1.
- Start while Busy: ignored. It has no effect on the counters.
- Abort: has priority over acceptance in the same cycle.
  - Next edge: state=IDLE and counters cleared.
  - SR_Enable, WinValid and FrameDone are forced to 0.
  - The shift register contents are left stale; the next frame refills them.
- Start and Abort in the same cycle while in IDLE: Abort wins and the state stays IDLE.
- Back-to-back frames: a Start in the cycle after LAST→IDLE is accepted. The minimum gap between frames is 1 idle cycle.
- Counter arithmetic is unsigned, with wrap compares against the parameters (IMG_W-1, IMG_H-1). No overflow is possible.

Decomposition:
- Package sobel_pkg holds:
  - DATA_W.
  - Defaults for IMG_W and IMG_H.
  - A 2-bit state enum: IDLE=0, LOAD=1, LAST=2.
- Sub-module pixel_coord_counter holds the column/row counters. Its ports are clear, inc, col, row, last_pix (asserted at (IMG_H-1, IMG_W-1)), parameterised by IMG_W and IMG_H.

Test Plan:
- Basic frame. Setup: IMG_W=4, IMG_H=3; reset; Start; PixValid held 1 with PixData=0..11. Expected: 12 SR_Enable pulses with SR_DataIn=0..11, each 1 cycle after acceptance; WinValid exactly at (2,2) and (2,3), i.e. data 10 and 11; FrameDone coincident with data 11; Busy low 2 cycles after the last acceptance.
- Stall. Same frame with PixValid low for 3 cycles after pixel 5. Expected: SR_Enable low for those 3 cycles; Col=1/Row=1 held; PixReady stays 1; remaining sequence unchanged.
- Abort mid-frame. Abort asserted at pixel 7. Expected: next cycle IDLE, PixReady=0, no FrameDone. A following Start restarts at Col=0, Row=0.
- Asynchronous reset. RST_N pulsed low mid-cycle during LOAD. Expected: all outputs 0 immediately, without waiting for a clock edge; state=IDLE after release.
- Start while Busy. A Start pulse at pixel 4. Expected: no counter reset; the frame completes with 12 pushes.
- Back-to-back frames. Start issued 1 cycle after the first frame's IDLE entry. Expected: the second frame accepted, with identical WinValid/FrameDone timing.
